// File: rtl/sram_arb.sv
// sram_arb: two-port arbiter and timing sequencer for an async SRAM; define SRAM_ARB_PRIO_EN for fixed port-A priority instead of round-robin
module sram_arb #(
  parameter int AW = 19,
  parameter int DW = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [1:0]    a_be,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic [1:0]    b_be,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_dq,
  output logic          sram_nwe,
  output logic          sram_noe,
  output logic          sram_nce,
  output logic          sram_nlb,
  output logic          sram_nub
);
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;
  state_t        st;
  logic [3:0]    cnt;
  logic          lat_we, lat_b, dq_oe, grant_b, g_we;
  logic [DW-1:0] wdata_q, g_wdata;
  logic [AW-1:0] g_addr;
  logic [1:0]    g_be;
  assign sram_dq = dq_oe ? wdata_q : 'z;
`ifdef SRAM_ARB_PRIO_EN
  // fixed priority: B only wins when A is not asking
  always_comb grant_b = b_req & ~a_req;
`else
  logic last_b;
  // round-robin: on a tie the port not served last wins
  always_comb grant_b = b_req & (~a_req | ~last_b);
  // remember which port was granted most recently; B after reset so A wins the first tie
  always_ff @(posedge clk)
    if (!rstn) last_b <= 1'b1;
    else if (st == IDLE && (a_req || b_req)) last_b <= grant_b;
`endif
  // select the winning request's fields
  always_comb begin
    g_we    = grant_b ? b_we    : a_we;
    g_addr  = grant_b ? b_addr  : a_addr;
    g_wdata = grant_b ? b_wdata : a_wdata;
    g_be    = grant_b ? b_be    : a_be;
  end
  // access sequencer: IDLE -> ACCESS (WAIT_CYC cycles) -> HOLD (ack) -> IDLE, all pins registered
  always_ff @(posedge clk)
    if (!rstn) begin
      st        <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_b     <= 1'b0;
      dq_oe     <= 1'b0;
      wdata_q   <= '0;
      sram_addr <= '0;
      sram_nwe  <= 1'b1;
      sram_noe  <= 1'b1;
      sram_nce  <= 1'b1;
      sram_nlb  <= 1'b1;
      sram_nub  <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (st)
        IDLE:
          if (a_req || b_req) begin
            st        <= ACCESS;
            cnt       <= '0;
            lat_b     <= grant_b;
            lat_we    <= g_we;
            sram_addr <= g_addr;
            wdata_q   <= g_wdata;
            sram_nlb  <= ~g_be[0];
            sram_nub  <= ~g_be[1];
            sram_nce  <= 1'b0;
            sram_noe  <= g_we;
            sram_nwe  <= ~g_we;
            dq_oe     <= g_we;
          end
        ACCESS:
          if (cnt == 4'(WAIT_CYC - 1)) begin
            st       <= HOLD;
            sram_noe <= 1'b1;
            sram_nwe <= 1'b1;
            a_ack    <= ~lat_b;
            b_ack    <= lat_b;
            if (!lat_we && !lat_b) a_rdata <= sram_dq;
            if (!lat_we && lat_b) b_rdata <= sram_dq;
          end else cnt <= cnt + 4'd1;
        HOLD: begin
          st       <= IDLE;
          sram_nce <= 1'b1;
          sram_nlb <= 1'b1;
          sram_nub <= 1'b1;
          dq_oe    <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
endmodule
